// File: rtl/sorter_pkg.sv
// Shared types and defaults for the byte sorter pipeline.
// The load stage imports the state enum, element defaults and padding value from here.
package sorter_pkg;

    localparam int SORTER_W = 8;
    localparam int SORTER_N = 5;

    // All-ones padding sorts last under ascending order.
    localparam logic [SORTER_W-1:0] PAD = '1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } load_state_t;

    typedef logic [SORTER_N-1:0][SORTER_W-1:0] frame_t;

endpackage

// File: rtl/sorter_load_stage.sv
// Serial-to-parallel load stage: gathers N elements into a frame and hands it downstream.
// Optional early-completion input in_flush is enabled by defining SORTER_LOAD_FLUSH_EN.
module sorter_load_stage
    import sorter_pkg::*;
#(
    parameter int W  = SORTER_W,
    parameter int N  = SORTER_N,
    parameter int CW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N*W-1:0]         out_frame,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N+1)-1:0] fill_count,
`ifdef SORTER_LOAD_FLUSH_EN
    input  logic                   in_flush,
`endif
    output logic [CW-1:0]          frame_cnt
);

    localparam int FCW = $clog2(N+1);
    localparam logic [W-1:0] FILL_PAD = {W{1'b1}};

    load_state_t              state;
    logic [N-1:0][W-1:0]      slots;
    logic                     accept;

    // A full frame frees its slot only when the consumer takes it this cycle.
    assign in_ready  = (state == FILL) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == FULL);
    assign out_frame = slots;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            fill_count <= '0;
            frame_cnt  <= '0;
            slots      <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < N; k++) begin
                            if (fill_count == FCW'(k)) begin
                                slots[k] <= in_data;
                            end
                        end
                    end
`ifdef SORTER_LOAD_FLUSH_EN
                    // Same-cycle element lands at fill_count; padding covers the rest.
                    if (in_flush && (accept || fill_count != '0)) begin
                        for (int k = 0; k < N; k++) begin
                            if ((FCW'(k) > fill_count) ||
                                (!accept && FCW'(k) == fill_count)) begin
                                slots[k] <= FILL_PAD;
                            end
                        end
                        fill_count <= FCW'(N);
                        state      <= FULL;
                    end else
`endif
                    if (accept) begin
                        if (fill_count == FCW'(N-1)) begin
                            fill_count <= FCW'(N);
                            state      <= FULL;
                        end else begin
                            fill_count <= fill_count + FCW'(1);
                        end
                    end
                end
                FULL: begin
                    // Handoff may coincide with the first element of the next frame.
                    if (out_ready) begin
                        frame_cnt <= frame_cnt + CW'(1);
                        state     <= FILL;
                        if (accept) begin
                            slots[0]   <= in_data;
                            fill_count <= FCW'(1);
                        end else begin
                            fill_count <= '0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_load_stage.sv
// Self-checking bench for sorter_load_stage against a queue-based frame model.
// Define SORTER_LOAD_FLUSH_EN to also exercise the early-flush input.
module tb_sorter_load_stage;

    localparam int W  = 8;
    localparam int N  = 5;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] out_frame;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     fill_count;
    logic [CW-1:0]  frame_cnt;
    logic           in_flush;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] held[$];
    int           model_frames = 0;
    logic [N*W-1:0] saved_frame;

    always #5 clk = ~clk;

    sorter_load_stage #(.W(W), .N(N), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_frame(out_frame),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fill_count(fill_count),
`ifdef SORTER_LOAD_FLUSH_EN
        .in_flush(in_flush),
`endif
        .frame_cnt(frame_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Expected outputs derived from the model's held-element list.
    task automatic compareAll();
        logic [N*W-1:0] exp_frame;
        exp_frame = '0;
        for (int k = 0; k < held.size(); k++) exp_frame[k*W +: W] = held[k];
        checkOutput("out_valid", 64'(out_valid), 64'(held.size() == N));
        checkOutput("fill_count", 64'(fill_count), 64'(held.size()));
        checkOutput("frame_cnt", 64'(frame_cnt), 64'(model_frames % (1 << CW)));
        checkOutput("in_ready", 64'(in_ready), 64'((held.size() < N) || out_ready));
        if (held.size() == N) checkOutput("out_frame", 64'(out_frame), 64'(exp_frame));
    endtask

    task automatic modelUpdate(input logic r, input logic v, input logic [W-1:0] d,
                               input logic ordy, input logic fl);
        bit full, acc;
        full = (held.size() == N);
        acc  = v && (!full || ordy);
        if (r) begin
            held.delete();
            model_frames = 0;
        end else if (full) begin
            if (ordy) begin
                model_frames++;
                held.delete();
                if (acc) held.push_back(d);
            end
        end else begin
            if (acc) held.push_back(d);
`ifdef SORTER_LOAD_FLUSH_EN
            if (fl && held.size() > 0) begin
                while (held.size() < N) held.push_back({W{1'b1}});
            end
`endif
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance both.
    task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d,
                                 input logic ordy, input logic fl);
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; out_ready = ordy; in_flush = fl;
        #1;
        compareAll();
        modelUpdate(r, v, d, ordy, fl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] seq [5];
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; in_flush = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        held.delete(); model_frames = 0;

        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_fill_count", 64'(fill_count), 64'd0);
        checkOutput("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        checkOutput("reset_out_frame", 64'(out_frame), 64'd0);

        // Basic frame assembly and element ordering.
        seq = '{8'h30, 8'h10, 8'h50, 8'h20, 8'h40};
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, seq[i], 1'b1, 1'b0);
        checkOutput("frame1_valid", 64'(out_valid), 64'd1);
        checkOutput("frame1_data", 64'(out_frame), 64'h40_20_50_10_30);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("frame1_cnt", 64'(frame_cnt), 64'd1);
        checkOutput("frame1_drained", 64'(out_valid), 64'd0);

        // Backpressure holds the frame and blocks input.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
        saved_frame = out_frame;
        checkOutput("hold_frame_lit", 64'(saved_frame), 64'h65_64_63_62_61);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput("hold_frame", 64'(out_frame), 64'h65_64_63_62_61);
        checkOutput("hold_fill", 64'(fill_count), 64'd5);
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        checkOutput("release_fill", 64'(fill_count), 64'd1);
        checkOutput("release_slot0", 64'(out_frame[7:0]), 64'hAA);
        checkOutput("release_cnt", 64'(frame_cnt), 64'd2);

        // Continuous streaming: 20 elements, four frames.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 8'(i + 1), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("stream_cnt", 64'(frame_cnt), 64'd4);
        checkOutput("stream_fill", 64'(fill_count), 64'd0);

        // Reset in the middle of a frame discards it.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("midrst_fill", 64'(fill_count), 64'd0);
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
        checkOutput("midrst_frame", 64'(out_frame), 64'hD4_D3_D2_D1_D0);

        // Counter wrap: 17 handoffs with a 4-bit counter.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 85; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("wrap_cnt", 64'(frame_cnt), 64'd1);

`ifdef SORTER_LOAD_FLUSH_EN
        // Early flush pads the remaining slots.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("flush_valid", 64'(out_valid), 64'd1);
        checkOutput("flush_frame", 64'(out_frame), 64'hFF_FF_FF_03_07);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("flush_empty", 64'(out_valid), 64'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic r, v, o, f;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 6);
            f = 1'b0;
`ifdef SORTER_LOAD_FLUSH_EN
            f = ($urandom_range(0, 19) == 0);
`endif
            applyStimulus(r, v, 8'($urandom), o, f);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
